// File: rtl/lcd_write_scheduler_pkg.sv
// Shared types and constants for the LCD write scheduler.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    S_INIT_ISSUE = 3'd0,
    S_INIT_WAIT  = 3'd1,
    S_IDLE       = 3'd2,
    S_ISSUE      = 3'd3,
    S_WAIT       = 3'd4,
    S_LINE_ISSUE = 3'd5,
    S_LINE_WAIT  = 3'd6
  } sched_state_e;

  localparam int LCD_INIT_LEN = 5;

  // Function set 8-bit/2-line, display on, clear, entry mode, home address.
  localparam logic [8:0] LCD_INIT_SEQ [0:LCD_INIT_LEN-1] = '{
    9'h038, 9'h00C, 9'h001, 9'h006, 9'h080
  };

  localparam logic [8:0] LCD_CLEAR         = 9'h001;
  localparam logic [8:0] LCD_HOME          = 9'h002;
  localparam logic [8:0] LCD_LINE_CMD_BASE = 9'h080;

  typedef struct packed {
    logic       is_char;
    logic [7:0] code;
  } req_word_t;

endpackage

// File: rtl/lcd_write_scheduler_if.sv
// Request and LCD-controller signal bundle for the LCD write scheduler.
interface lcd_write_scheduler_if;
  logic [1:0] Req_valid;
  logic [8:0] Req_data [0:1];
  logic [1:0] Req_ready;
  logic       LCD_start;
  logic [8:0] LCD_instruction;
  logic       LCD_done;
  logic       Init_done;
  logic       Busy;
  logic [3:0] Cursor_col;
  logic       Cursor_line;

  modport master (
    input  Req_valid, Req_data, LCD_done,
    output Req_ready, LCD_start, LCD_instruction, Init_done, Busy,
           Cursor_col, Cursor_line
  );

  modport slave (
    output Req_valid, Req_data, LCD_done,
    input  Req_ready, LCD_start, LCD_instruction, Init_done, Busy,
           Cursor_col, Cursor_line
  );
endinterface

// File: rtl/lcd_write_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // One-hot-or-zero grant, zero whenever arbitration is disabled.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Shares one LCD controller between two requesters: runs the init
// sequence, arbitrates round-robin, tracks the cursor and inserts a
// line-change instruction after the last column of a line.
module lcd_write_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int LINE_LENGTH = 16
) (
  input  logic Clock_50,
  input  logic Resetn,
  lcd_write_scheduler_if.master bus
);

  localparam logic [3:0] LAST_COL = 4'(LINE_LENGTH - 1);

  sched_state_e state_q, state_d;
  logic [2:0]   init_idx_q, init_idx_d;
  logic         last_grant_q, last_grant_d;
  logic         start_q, start_d;
  logic [8:0]   instr_q, instr_d;
  logic         init_done_q, init_done_d;
  logic [3:0]   col_q, col_d;
  logic         line_q, line_d;
  logic         armed_q, armed_d;
  req_word_t    word_q, word_d;
  logic [1:0]   grant;
  logic         arb_en;

  function automatic logic [3:0] sat_col(input logic [3:0] c);
    return (c > LAST_COL) ? LAST_COL : c;
  endfunction

  assign arb_en = (state_q == S_IDLE);

  rr_arbiter_2 u_arb (
    .valid      (bus.Req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign bus.Req_ready       = grant;
  assign bus.LCD_start       = start_q;
  assign bus.LCD_instruction = instr_q;
  assign bus.Init_done       = init_done_q;
  assign bus.Busy            = (state_q != S_IDLE);
  assign bus.Cursor_col      = col_q;
  assign bus.Cursor_line     = line_q;

  // Next-state logic: init sequencing, grant latch, LCD handshake, cursor.
  // armed_q masks LCD_done during the first cycle of every wait state.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    last_grant_d = last_grant_q;
    start_d      = 1'b0;
    instr_d      = instr_q;
    init_done_d  = init_done_q;
    col_d        = col_q;
    line_d       = line_q;
    armed_d      = armed_q;
    word_d       = word_q;
    case (state_q)
      S_INIT_ISSUE: begin
        instr_d = LCD_INIT_SEQ[init_idx_q];
        start_d = 1'b1;
        armed_d = 1'b0;
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (bus.LCD_done) begin
          if (init_idx_q == 3'(LCD_INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
            state_d    = S_INIT_ISSUE;
          end
        end
      end
      S_IDLE: begin
        if (grant != 2'b00) begin
          word_d       = req_word_t'(grant[1] ? bus.Req_data[1] : bus.Req_data[0]);
          last_grant_d = grant[1];
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr_d = word_q;
        start_d = 1'b1;
        armed_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (bus.LCD_done) begin
          if (word_q.is_char) begin
            if (col_q < LAST_COL) begin
              col_d   = col_q + 4'd1;
              state_d = S_IDLE;
            end else begin
              col_d   = 4'd0;
              state_d = S_LINE_ISSUE;
            end
          end else begin
            if (word_q == LCD_CLEAR || word_q[8:1] == LCD_HOME[8:1]) begin
              col_d  = 4'd0;
              line_d = 1'b0;
            end else if (word_q.code[7]) begin
              line_d = word_q.code[6];
              col_d  = sat_col(word_q.code[3:0]);
            end
            state_d = S_IDLE;
          end
        end
      end
      S_LINE_ISSUE: begin
        instr_d = LCD_LINE_CMD_BASE | {2'b00, ~line_q, 6'h00};
        line_d  = ~line_q;
        start_d = 1'b1;
        armed_d = 1'b0;
        state_d = S_LINE_WAIT;
      end
      S_LINE_WAIT: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (bus.LCD_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT_ISSUE;
    endcase
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_INIT_ISSUE;
      init_idx_q   <= 3'd0;
      last_grant_q <= 1'b1;
      start_q      <= 1'b0;
      instr_q      <= 9'h000;
      init_done_q  <= 1'b0;
      col_q        <= 4'd0;
      line_q       <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      last_grant_q <= last_grant_d;
      start_q      <= start_d;
      instr_q      <= instr_d;
      init_done_q  <= init_done_d;
      col_q        <= col_d;
      line_q       <= line_d;
      armed_q      <= armed_d;
    end
  end

  // Granted request word; only read after it has been loaded in S_IDLE.
  always_ff @(posedge Clock_50) begin
    word_q <= word_d;
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Bench for lcd_write_scheduler: LCD controller stand-in with varied
// latency, transaction-level model of the expected instruction stream,
// grants and cursor, plus directed scenarios with literal expectations.
module tb_lcd_write_scheduler;

  localparam int LL = 16;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [8:0] d0 = 9'h000, d1 = 9'h000;
  logic       done = 1'b0;

  always #10 clk = ~clk;

  lcd_write_scheduler_if bus();
  assign bus.Req_valid   = {v1, v0};
  assign bus.Req_data[0] = d0;
  assign bus.Req_data[1] = d1;
  assign bus.LCD_done    = done;

  lcd_write_scheduler #(.LINE_LENGTH(LL)) dut (
    .Clock_50 (clk),
    .Resetn   (rstn),
    .bus      (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // LCD controller stand-in: done rises N cycles after a start, held until the next start
  int nstart = 0, cnt = 0, force_lat = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      done = 1'b0;
      cnt  = 0;
    end else if (bus.LCD_start) begin
      done = 1'b0;
      cnt  = (force_lat != 0) ? force_lat : 1 + ((nstart * 7) % 20);
      nstart++;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) done = 1'b1;
    end
  end

  // Behavioural model state
  logic [8:0] expq[$];
  int         m_col, m_line;
  logic       m_last;
  logic       prev_start;
  logic [8:0] log_i [0:511];
  int         nlog = 0;
  int         grants [0:255];
  int         ngrant = 0;
  int         ready0_cnt = 0;

  task automatic model_reset();
    logic [8:0] init_words [0:4];
    init_words = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    expq.delete();
    for (int i = 0; i < 5; i++) expq.push_back(init_words[i]);
    m_col      = 0;
    m_line     = 0;
    m_last     = 1'b1;
    prev_start = 1'b0;
  endtask

  task automatic apply_word(input logic [8:0] w);
    int absp;
    expq.push_back(w);
    if (w[8]) begin
      absp = (m_line * LL + m_col + 1) % (2 * LL);
      m_line = absp / LL;
      m_col  = absp % LL;
      if (m_col == 0) expq.push_back(m_line ? 9'h0C0 : 9'h080);
    end else if (w == 9'h001 || w == 9'h002 || w == 9'h003) begin
      m_col  = 0;
      m_line = 0;
    end else if (w[7]) begin
      m_line = w[6];
      m_col  = (int'(w[3:0]) > LL - 1) ? LL - 1 : int'(w[3:0]);
    end
  endtask

  // Compare process: every falling edge while out of reset
  always @(negedge clk) begin
    logic [1:0] exp_ready, hs;
    if (!rstn) begin
      model_reset();
    end else begin
      if (bus.LCD_start) begin
        chk("start_width", prev_start, 1'b0);
        if (nlog < 512) log_i[nlog] = bus.LCD_instruction;
        nlog++;
        chk("start_expected", expq.size() > 0, 1);
        if (expq.size() > 0) chk("instruction", bus.LCD_instruction, expq.pop_front());
      end
      prev_start = bus.LCD_start;

      if (bus.Busy || !bus.Init_done) exp_ready = 2'b00;
      else if (bus.Req_valid == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
      else exp_ready = bus.Req_valid;
      chk("req_ready", bus.Req_ready, exp_ready);

      if (!bus.Init_done) chk("busy_during_init", bus.Busy, 1'b1);
      if (!bus.Busy) begin
        chk("init_done_idle", bus.Init_done, 1'b1);
        chk("cursor_col", bus.Cursor_col, m_col);
        chk("cursor_line", bus.Cursor_line, m_line);
        chk("pending_instr", expq.size(), 0);
      end

      if (bus.Req_ready[0]) ready0_cnt++;
      hs = bus.Req_valid & bus.Req_ready;
      if (hs != 2'b00) begin
        if (ngrant < 256) grants[ngrant] = hs[1];
        ngrant++;
        m_last = hs[1];
        apply_word(hs[1] ? d1 : d0);
      end
    end
  end

  task automatic send(input int r, input logic [8:0] w);
    bit ok;
    @(posedge clk); #1;
    if (r == 0) begin v0 = 1'b1; d0 = w; end
    else begin v1 = 1'b1; d1 = w; end
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (bus.Req_ready[r]) ok = 1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      chk("ready_timeout", bus.Req_ready[r], 1'b1);
    end
    if (r == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.Busy && bus.Init_done) return;
    end
    chk("idle_timeout", bus.Busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         l0, g0, r0c;
    logic [8:0] init_exp [0:4];
    logic [8:0] t4_exp [0:5];
    init_exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    t4_exp   = '{9'h141, 9'h161, 9'h142, 9'h162, 9'h143, 9'h163};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start", bus.LCD_start, 1'b0);
    chk("rst_instr", bus.LCD_instruction, 9'h000);
    chk("rst_init_done", bus.Init_done, 1'b0);
    chk("rst_col", bus.Cursor_col, 4'd0);
    chk("rst_line", bus.Cursor_line, 1'b0);
    chk("rst_ready", bus.Req_ready, 2'b00);
    #2 rstn = 1'b1;

    // 1: init sequence
    wait_idle();
    chk("init_count", nlog, 5);
    for (int i = 0; i < 5; i++) chk("init_word", log_i[i], init_exp[i]);
    chk("init_done", bus.Init_done, 1'b1);
    chk("init_busy", bus.Busy, 1'b0);

    // 2: single character
    r0c = ready0_cnt;
    send(0, 9'h141);
    wait_idle();
    chk("t2_instr", bus.LCD_instruction, 9'h141);
    chk("t2_starts", nlog, 6);
    chk("t2_col", bus.Cursor_col, 4'd1);
    chk("t2_ready_cycles", ready0_cnt - r0c, 1);

    // 3: line wrap both ways
    send(0, 9'h080);
    for (int i = 0; i < 16; i++) send(0, 9'h130 + 9'(i));
    wait_idle();
    chk("t3_linecmd1", log_i[nlog-1], 9'h0C0);
    chk("t3_lastchar", log_i[nlog-2], 9'h13F);
    chk("t3_col1", bus.Cursor_col, 4'd0);
    chk("t3_line1", bus.Cursor_line, 1'b1);
    for (int i = 0; i < 16; i++) send(0, 9'h150 + 9'(i));
    wait_idle();
    chk("t3_linecmd0", log_i[nlog-1], 9'h080);
    chk("t3_line0", bus.Cursor_line, 1'b0);

    // 4: both requesters contend, 3 words each
    send(1, 9'h006);
    wait_idle();
    g0 = ngrant;
    l0 = nlog;
    fork
      begin send(0, 9'h141); send(0, 9'h142); send(0, 9'h143); end
      begin send(1, 9'h161); send(1, 9'h162); send(1, 9'h163); end
    join
    wait_idle();
    chk("t4_grant_count", ngrant - g0, 6);
    for (int k = 0; k < 6; k++) begin
      chk("t4_grant", grants[g0+k], k % 2);
      chk("t4_word", log_i[l0+k], t4_exp[k]);
    end

    // 5: cursor commands
    send(0, 9'h0C5);
    wait_idle();
    chk("t5_col5", bus.Cursor_col, 4'd5);
    chk("t5_line1", bus.Cursor_line, 1'b1);
    send(1, 9'h001);
    wait_idle();
    chk("t5_clear_instr", bus.LCD_instruction, 9'h001);
    chk("t5_clear_col", bus.Cursor_col, 4'd0);
    chk("t5_clear_line", bus.Cursor_line, 1'b0);
    send(1, 9'h0C7);
    wait_idle();
    chk("t5_col7", bus.Cursor_col, 4'd7);
    chk("t5_line_c7", bus.Cursor_line, 1'b1);
    send(1, 9'h0CF);
    send(0, 9'h14F);
    wait_idle();
    chk("t5_wrap_cmd", log_i[nlog-1], 9'h080);
    chk("t5_wrap_line", bus.Cursor_line, 1'b0);

    // 6: reset during S_WAIT
    force_lat = 20;
    send(0, 9'h142);
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_start", bus.LCD_start, 1'b0);
    chk("t6_instr", bus.LCD_instruction, 9'h000);
    chk("t6_init_done", bus.Init_done, 1'b0);
    chk("t6_col", bus.Cursor_col, 4'd0);
    chk("t6_line", bus.Cursor_line, 1'b0);
    chk("t6_ready", bus.Req_ready, 2'b00);
    chk("t6_busy", bus.Busy, 1'b1);
    force_lat = 0;
    repeat (2) @(negedge clk);
    l0 = nlog;
    #2 rstn = 1'b1;
    wait_idle();
    chk("t6_init_count", nlog - l0, 5);
    for (int i = 0; i < 5; i++) chk("t6_init_word", log_i[l0+i], init_exp[i]);
    send(0, 9'h141);
    wait_idle();
    chk("t6_after_col", bus.Cursor_col, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
